// File: rtl/mul_acc_p_pkg.sv
// Shared definitions for the mul_acc_p multiply-accumulate block:
// default operand width, FSM state encodings and a counter-width helper.
package mul_acc_p_pkg;

    // Default operand width in bits.
    localparam int DATAWIDTH = 8;

    // FSM state encodings.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that must reach the value w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_acc_p.sv
// mul_acc_p: constant-time shift-and-add multiplier computing a*b+c.
// An operation is captured in IDLE, runs exactly WIDTH MULT cycles (no
// early exit when the multiplier runs out of ones, so latency never
// depends on operand values), then a DONE cycle registers the result and
// emits a one-cycle ready pulse. The result is 2*WIDTH+2 bits wide so it
// can feed the x input of the downstream modulo-p stage directly.
module mul_acc_p
    import mul_acc_p_pkg::*;
#(
    parameter int WIDTH = DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH:0]     c,
    output logic [2*WIDTH+1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    // Accumulator and shifted multiplicand share the full result width:
    // (2^W-1)^2 + (2^(2W+1)-1) < 2^(2W+2), so nothing can overflow.
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q,  state_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [ACC_W-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ready_q,  ready_d;

    // Next-state logic: capture in IDLE, one shift-and-add step per MULT
    // cycle, publish the accumulator in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    acc_d    = ACC_W'(c);
                    mcand_d  = ACC_W'(a);
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = ST_MULT;
                end
            end
            ST_MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                // Leave on the edge where cnt reaches WIDTH.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_d = acc_q;
                ready_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously
    // so an aborted operation can never produce a ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    // Busy in MULT and DONE; state is forced to IDLE by reset, so busy
    // drops immediately when rst_n goes low.
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_acc_p.sv
// Directed bench for mul_acc_p at WIDTH=8: table of single operations plus
// hand-written sequences for back-to-back operation and mid-run reset.
module tb_mul_acc_p;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [16:0] c;
    logic [17:0] result;
    logic        ready;
    logic        busy;

    int errors;
    int checks;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] c;
        logic [17:0] r;
        string       nm;
    } vec_t;

    vec_t vecs[8];

    mul_acc_p #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .a      (a),
        .b      (b),
        .c      (c),
        .result (result),
        .ready  (ready),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One operation: enable pulse on the capturing edge, operands scrambled
    // afterwards, ready expected exactly 9 edges later.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [16:0] tc, input logic [17:0] exp,
                          input string nm);
        int lat;
        int bcnt;
        @(negedge clk);
        a = ta; b = tb_v; c = tc; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        a = ~ta; b = ~tb_v; c = ~tc;
        chk({nm, " busy_start"}, 32'(busy), 32'd1);
        bcnt = 1;
        lat  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd9);
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'd9);
        chk({nm, " result"}, 32'(result), 32'(exp));
        chk({nm, " busy_at_ready"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " ready_width"}, 32'(ready), 32'd0);
        chk({nm, " result_hold"}, 32'(result), 32'(exp));
    endtask

    initial begin
        int lat;
        int seen;
        errors = 0;
        checks = 0;

        vecs[0] = '{8'hFF, 8'hFF, 17'h00000, 18'h0FE01, "ff_ff_c0"};
        vecs[1] = '{8'hFF, 8'hFF, 17'h1FFFF, 18'h2FE00, "ff_ff_cmax"};
        vecs[2] = '{8'h00, 8'h5A, 17'h00000, 18'h00000, "a_zero"};
        vecs[3] = '{8'h5A, 8'h00, 17'h00000, 18'h00000, "b_zero"};
        vecs[4] = '{8'h03, 8'h05, 17'h00007, 18'h00016, "3x5p7"};
        vecs[5] = '{8'h80, 8'h02, 17'h00010, 18'h00110, "msb_shift"};
        vecs[6] = '{8'hAB, 8'hCD, 17'h00100, 18'h089EF, "ab_cd"};
        vecs[7] = '{8'h12, 8'h34, 17'h00000, 18'h003A8, "12_34"};

        rst_n = 1'b0; enable = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r, vecs[i].nm);
        end

        // Idle with enable low: result must hold.
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold_result", 32'(result), 32'h3A8);
        chk("idle_hold_busy", 32'(busy), 32'd0);

        // Enable held high; operands change mid-operation.
        @(negedge clk);
        a = 8'd3; b = 8'd5; c = 17'd7; enable = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd1; b = 8'd1; c = 17'd0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
        chk("cont_first_latency", 32'(lat), 32'd9);
        chk("cont_first_result", 32'(result), 32'd22);
        @(posedge clk);
        #1;
        enable = 1'b0;
        chk("cont_restart_busy", 32'(busy), 32'd1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
        chk("cont_period", 32'(lat + 1), 32'd10);
        chk("cont_second_result", 32'(result), 32'd1);

        // Reset in the 4th MULT cycle aborts the operation.
        @(negedge clk);
        a = 8'h12; b = 8'h34; c = 17'd0; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (ready || busy) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        run_op(8'h12, 8'h34, 17'd0, 18'h003A8, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_acc_p.md
MUL_ACC_P -- requirements
Module: mul_acc_p

Interface
REQ-001 The block SHALL have parameter WIDTH, default `DATAWIDTH (from parameters.vh), meaning the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-007 The block SHALL have port c, input, 2*WIDTH+1 bits: addend.
REQ-008 The block SHALL have port result, output, 2*WIDTH+2 bits: a*b+c, sized to drive the x input of the downstream modulo-p stage directly.
REQ-009 The block SHALL have port ready, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.

Function
REQ-011 The block SHALL implement FSM states IDLE, MULT and DONE.
REQ-012 In IDLE with enable=1 at a rising edge, the block SHALL capture a, b and c, set acc=zero-extended c and cnt=0, and go to MULT.
REQ-013 In IDLE with enable=0, the block SHALL hold all registers, including result.
REQ-014 In each MULT cycle, the block SHALL perform: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt += 1.
REQ-015 The block SHALL keep mcand 2*WIDTH+2 bits wide, so no carry or shifted bit is lost.
REQ-016 The block SHALL go from MULT to DONE on the edge where cnt reaches WIDTH, giving exactly WIDTH MULT cycles.
REQ-017 The block SHALL NOT exit early when mplier becomes zero; latency SHALL be constant for all operands (constant-time requirement).
REQ-018 In DONE, the block SHALL register result=acc and ready=1, then go to IDLE on the next edge.
REQ-019 The ready pulse SHALL be exactly one cycle wide.
REQ-020 Latency: if the capturing edge is edge k, ready and the new result SHALL appear after edge k+WIDTH+1.
REQ-021 result SHALL stay stable from that edge until the next DONE.
REQ-022 busy SHALL be 1 in MULT and DONE and 0 in IDLE.
REQ-023 The block SHALL ignore enable while in MULT or DONE; operand changes during an operation SHALL have no effect.
REQ-024 With enable held high continuously, the block SHALL start a new operation on the first IDLE edge after DONE, giving one operation per WIDTH+2 cycles.
REQ-025 The block SHALL NOT overflow: (2^WIDTH-1)^2 + (2^(2*WIDTH+1)-1) < 2^(2*WIDTH+2).

Reset
REQ-026 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, result=0, ready=0, busy=0, and acc, mcand, mplier and cnt to 0, regardless of clk.
REQ-027 Reset mid-operation SHALL abort that operation with no ready pulse.
REQ-028 The first enable sampled after rst_n rises SHALL start a clean operation.

Structure
REQ-029 The state encodings (IDLE=2'd0, MULT=2'd1, DONE=2'd2) and DATAWIDTH SHALL live in the shared parameters.vh header.
REQ-030 The cnt width SHALL be $clog2(WIDTH+1).
REQ-031 The block SHALL be a single module with no sub-module; the adder and shifters SHALL be inline.

Verification (bench uses WIDTH=8; x = don't care)
REQ-032 a=8'hFF, b=8'hFF, c=0, enable pulse at edge k -> ready=1 only after edge k+9, result=18'h0FE01, busy high for 9 cycles.
REQ-033 a=8'hFF, b=8'hFF, c=17'h1FFFF -> result=18'h2FE00 (no overflow), same latency.
REQ-034 a=0, b=8'h5A, c=0, then a=8'h5A, b=0 -> both result=0, and ready after exactly 9 edges each (constant time).
REQ-035 enable held high with a=3, b=5, c=7, then a/b/c changed to 1/1/0 during MULT -> result=22, and the next op starts the edge after DONE, giving result=1 at period 10.
REQ-036 rst_n pulled low mid-MULT (4th cycle) of a=8'h12, b=8'h34 -> result, ready and busy=0 immediately with no ready pulse; a subsequent a=8'h12, b=8'h34, c=0 gives result=18'h003A8.
